// File: rtl/hs_fifo.sv
// hs_fifo -- parametrised valid/ready elastic buffer (DEPTH entries of WIDTH bits).
//
// Purpose:
//   Absorbs backpressure between a valid/ready producer and consumer with
//   full one-transfer-per-cycle throughput. ready_up, valid_down and count
//   come straight from flops. There is therefore no combinational path from
//   ready_down to ready_up, and none from valid_up to valid_down. An entry
//   pushed at edge N is visible at data_down from edge N; there is no bypass.
//
// Parameters:
//   WIDTH      data bits per entry (>= 1)
//   DEPTH      number of entries (power of two, >= 2)
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous reset, active-high (clears pointers and count)
//   valid_up   upstream offers data_up
//   data_up    upstream data
//   ready_up   buffer can accept an entry this cycle (count != DEPTH)
//   valid_down data_down holds a valid entry (count != 0)
//   data_down  head-of-queue data, read combinationally from storage
//   ready_down downstream accepts data_down this cycle
//   flush      synchronous clear; exists only when HS_FIFO_FLUSH_EN is defined
//   count      number of stored entries
//
// Configuration macro:
//   HS_FIFO_FLUSH_EN  adds the flush input and its clear logic. rst has
//                     priority over flush.

module hs_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_up,
  input  logic [WIDTH-1:0]         data_up,
  output logic                     ready_up,
  output logic                     valid_down,
  output logic [WIDTH-1:0]         data_down,
  input  logic                     ready_down,
`ifdef HS_FIFO_FLUSH_EN
  input  logic                     flush,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;

  logic             push_s;
  logic             pop_s;
  logic             wr_en_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_nxt_s;

  // Handshake decode and next-state computation for pointers and occupancy.
  always_comb begin
    push_s       = valid_up & ready_up;
    pop_s        = valid_down & ready_down;
    wr_en_s      = push_s;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count;
`ifdef HS_FIFO_FLUSH_EN
    if (flush) begin
      // Flush discards any transfer presented in the same cycle.
      wr_en_s      = 1'b0;
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
`endif
      // Pointers wrap modulo DEPTH by natural overflow (DEPTH is a power of two).
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count + CNT_W'(1);
        2'b01:   count_nxt_s = count - CNT_W'(1);
        default: count_nxt_s = count;
      endcase
`ifdef HS_FIFO_FLUSH_EN
    end
`endif
  end

  // Control state: pointers, occupancy and the flag flops decoded from next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count      <= {CNT_W{1'b0}};
      ready_up   <= 1'b1;
      valid_down <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count      <= count_nxt_s;
      ready_up   <= (count_nxt_s != CNT_W'(DEPTH));
      valid_down <= (count_nxt_s != {CNT_W{1'b0}});
    end
  end

  // Storage array; contents are deliberately not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_s) begin
      mem_r[wr_ptr_r] <= data_up;
    end
  end

  assign data_down = mem_r[rd_ptr_r];

endmodule
